dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
//   Parametrised data memory with load/store front end for the single-cycle core's successor.
//   Accepts byte/half/word requests over a valid/ready handshake and does byte-lane steering and sign/zero extension.
//   Splits misaligned, word-crossing accesses into two word beats under a small FSM.
//   Sits between the core's memory stage and an internal byte-masked word array; read data is registered.
// PARAMETERS
//   ADDR_W       11  byte-address width; array holds 2**(ADDR_W-2) 32-bit words
//   MISALIGN_EN  1   1: split word-crossing accesses into 2 beats; 0: flag them as errors
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst          in   1       synchronous, active-high reset
//   req_valid    in   1       request present
//   req_ready    out  1       block can accept; request taken when req_valid && req_ready
//   req_we       in   1       1 store, 0 load
//   req_addr     in   ADDR_W  byte address
//   req_size     in   2       00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned in   1       loads: 1 zero-extend, 0 sign-extend
//   req_wdata    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//   rsp_valid    out  1       one-cycle response pulse, no backpressure
//   rsp_rdata    out  32      extended load data; 0 for stores and errors
//   rsp_err      out  1       request rejected (reserved size, or misaligned with MISALIGN_EN=0)
// BEHAVIOUR
//   Reset: state IDLE, req_ready=1 after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0. Array contents are not reset.
//   Reset mid-SPLIT: beat 2 is aborted and no response is issued. A beat-1 store write that already happened is kept.
//   Byte i (0..n-1, n=1/2/4) of an access targets byte address addr+i.
//     Word index is addr[ADDR_W-1:2]; lane is addr[1:0].
//     Addresses wrap modulo 2**ADDR_W, so a split at the top word continues at word 0.
//   Crossing: access is crossing iff addr[1:0]+n > 4.
//     Non-crossing unaligned accesses, e.g. half at offset 1, are single-beat.
//   FSM IDLE (req_ready=1):
//     Non-crossing request: store writes the masked lanes at the accept edge; load captures the word at the accept edge.
//       Response: rsp_valid=1 in accept+1 cycle.
//     Crossing request, MISALIGN_EN=1: beat 1 handles the low word's lanes at the accept edge; go to SPLIT.
//     Crossing request, MISALIGN_EN=0: no array access, rsp_valid=1 with rsp_err=1 in accept+1 cycle.
//     req_size=11: no array access, rsp_err=1 in accept+1 cycle.
//   FSM SPLIT (req_ready=0):
//     Beat 2 accesses word index+1 (wrapped) for the remaining lanes, then goes to IDLE.
//     rsp_valid=1 in accept+2 cycle; rsp_err=0.
//   Throughput: 1 request/cycle for non-crossing traffic; crossing traffic costs 2 cycles.
//     A new request may be accepted in the same cycle rsp_valid is high.
//   Ordering: a load accepted the cycle after a store to an overlapping address returns the new data.
//   Load format: the assembled n bytes are extended to 32 bits per req_unsigned.
//     Size, offset and unsigned flag are registered at accept.
//   Inputs are ignored while req_ready=0.
//   rsp_rdata and rsp_err hold their last value when rsp_valid=0. They are only meaningful when rsp_valid=1.
// STRUCTURE
//   dmem_pkg: typedef enum size_e {SZ_B, SZ_H, SZ_W, SZ_RSV}; typedef enum state_e {IDLE, SPLIT};
//     function bytes_of(size_e).
//   Sub-module dmem_bank: 2**(ADDR_W-2) x 32 array.
//     Ports: 4-bit byte-enable write, registered read; one read-or-write per cycle.
//   dmem_lsu holds the FSM, lane rotation/masks, beat-1 word latch and extension logic.
// TESTING (ADDR_W=11)
//   sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp one cycle after each accept; load rdata=0xDEADBEEF, err=0.
//   lb @0x13 signed, then lbu @0x13 -> 0xFFFFFFDE and 0x000000DE; lh @0x11 -> 0xFFFFADBE, single beat.
//   MISALIGN_EN=1: sw 0x11223344 @0x22.
//     Words 0x20/0x24 receive lanes 2,3 / 0,1; req_ready=0 for one cycle; rsp at accept+2.
//     lw @0x22 -> 0x11223344.
//   Wrap: sh 0xA55A @0x7FF -> byte 0x7FF=0x5A, byte 0x000=0xA5; lhu @0x7FF -> 0x0000A55A.
//   MISALIGN_EN=0: lw @0x06 -> rsp_err=1, rdata=0, array unchanged. req_size=11 -> rsp_err=1.
//   Assert rst during SPLIT of sw @0x22 -> no rsp_valid; only low-word lanes written; req_ready=1 next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Size encodings, FSM states, byte counts, lane masks, load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_RSV
  } size_e;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  function automatic logic [2:0] bytes_of(size_e s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(size_e s);
    case (s)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(
    logic [31:0] d,
    size_e       s,
    logic        u
  );
    case (s)
      SZ_B:    return {{24{~u & d[7]}}, d[7:0]};
      SZ_H:    return {{16{~u & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the memory stage and dmem_lsu.
// master: core side drives req_*; slave: LSU drives req_ready and rsp_*.
interface dmem_lsu_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Word array with byte-enable write and registered read.
// Ports: i_en/i_we/i_be/i_idx/i_wdata request, o_rdata registered read word.
module dmem_bank #(
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [IW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [2**IW];

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_en && !i_we) o_rdata <= r_mem[i_idx];
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end: lane steering, word-crossing split FSM, extension.
// Ports: clk, rst (sync, active-high), bus (dmem_lsu_if slave).
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int MISALIGN_EN = 1
) (
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);
  localparam int IW = ADDR_W - 2;

  state_e        r_state;
  size_e         r_size;
  logic [1:0]    r_lane;
  logic          r_uns;
  logic          r_we;
  logic          r_two;
  logic          r_load;
  logic          r_rsp_valid;
  logic          r_err;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wd_hi;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_hold;

  size_e         w_size;
  logic [1:0]    w_lane;
  logic [IW-1:0] w_idx;
  logic [2:0]    w_n;
  logic          w_rsv;
  logic          w_cross;
  logic          w_err;
  logic          w_split;
  logic          w_acc;
  logic [7:0]    w_be8;
  logic [63:0]   w_wd64;
  logic [63:0]   w_asm;
  logic [31:0]   w_sh;
  logic [31:0]   w_rdata;
  logic [31:0]   w_bank_rd;
  logic          w_en;
  logic          w_we;
  logic [3:0]    w_be;
  logic [IW-1:0] w_bidx;
  logic [31:0]   w_bwd;

  assign w_size  = size_e'(bus.req_size);
  assign w_lane  = bus.req_addr[1:0];
  assign w_idx   = bus.req_addr[ADDR_W-1:2];
  assign w_n     = bytes_of(w_size);
  assign w_rsv   = (w_size == SZ_RSV);
  assign w_cross = ({1'b0, w_lane} + w_n) > 3'd4;
  assign w_err   = w_rsv || (w_cross && MISALIGN_EN == 0);
  assign w_split = w_cross && !w_rsv && MISALIGN_EN != 0;
  assign w_acc   = bus.req_valid && (r_state == IDLE);

  // Lanes past byte 3 spill into the next word (beat 2).
  assign w_be8  = {4'b0, lane_mask(w_size)} << w_lane;
  assign w_wd64 = {32'b0, bus.req_wdata} << {w_lane, 3'b0};

  always_comb begin
    w_en   = 1'b0;
    w_we   = 1'b0;
    w_be   = 4'b0;
    w_bidx = w_idx;
    w_bwd  = w_wd64[31:0];
    if (rst) begin
      w_en = 1'b0;
    end else if (r_state == SPLIT) begin
      w_en   = 1'b1;
      w_we   = r_we;
      w_be   = r_be_hi;
      w_bidx = r_idx + 1'b1;
      w_bwd  = r_wd_hi;
    end else if (w_acc && !w_err) begin
      w_en = 1'b1;
      w_we = bus.req_we;
      w_be = w_be8[3:0];
    end
  end

  dmem_bank #(.IW(IW)) u_bank (
    .clk     (clk),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_idx   (w_bidx),
    .i_wdata (w_bwd),
    .o_rdata (w_bank_rd)
  );

  // Split loads: low word latched during SPLIT, high word from the bank.
  assign w_asm = r_two ? {w_bank_rd, r_lo} : {32'b0, w_bank_rd};
  assign w_sh  = w_asm[{r_lane, 3'b0} +: 32];

  always_comb begin
    w_rdata = r_hold;
    if (r_rsp_valid) begin
      w_rdata = r_load ? extend(w_sh, r_size, r_uns) : 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_size      <= SZ_B;
      r_lane      <= 2'b0;
      r_uns       <= 1'b0;
      r_we        <= 1'b0;
      r_two       <= 1'b0;
      r_load      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wd_hi     <= 32'b0;
      r_be_hi     <= 4'b0;
      r_lo        <= 32'b0;
      r_hold      <= 32'b0;
    end else begin
      r_hold      <= w_rdata;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_lane  <= w_lane;
            r_size  <= w_size;
            r_uns   <= bus.req_unsigned;
            r_we    <= bus.req_we;
            r_idx   <= w_idx;
            r_wd_hi <= w_wd64[63:32];
            r_be_hi <= w_be8[7:4];
            if (w_split) begin
              r_state <= SPLIT;
            end else begin
              r_rsp_valid <= 1'b1;
              r_err       <= w_err;
              r_load      <= !bus.req_we && !w_err;
              r_two       <= 1'b0;
            end
          end
        end
        SPLIT: begin
          r_lo        <= w_bank_rd;
          r_state     <= IDLE;
          r_rsp_valid <= 1'b1;
          r_err       <= 1'b0;
          r_load      <= !r_we;
          r_two       <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = w_rdata;
endmodule
